match_sequencer: RTL and testbench

Top-level rally/match controller for the Pong game. It sequences serve, rally, point-hold and match-over phases, and owns both player scores. It drives the ball engine's enable/reset/serve direction from miss events reported by the ball/paddle logic. It replaces ad-hoc score counters with one registered Moore FSM on the 1 ms game tick.

---
 rtl/game_pkg.sv | 18 +
 rtl/phase_timer.sv | 28 ++
 rtl/match_sequencer.sv | 143 ++++++++++++++
 tb/tb_match_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared Pong game encodings: match phases and serve direction meanings.
// Pure declarations; no latency, no flow control.
package game_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        RALLY = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic SERVE_TO_P1 = 1'b0;
    localparam logic SERVE_TO_P2 = 1'b1;

endpackage

// File: rtl/phase_timer.sv
// Pausable up-counter with clear; flags expiry when it sits on 'last' while running.
// Expiry is combinational on the registered count; no backpressure, run gates counting.
module phase_timer #(
    parameter int W = 10
) (
    input  logic         clk_1ms,
    input  logic         reset,
    input  logic         clear,
    input  logic         run,
    input  logic [W-1:0] last,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = run && (cnt_q == last);

endmodule

// File: rtl/match_sequencer.sv
// Pong match controller: serve/rally/point/over phases, both scores, ball engine control.
// Inputs act on the next 1 ms tick; pause freezes phase timers and the ball.
module match_sequencer
    import game_pkg::*;
#(
    parameter int WIN_SCORE      = 7,
    parameter int SCORE_W        = 3,
    parameter int SERVE_DELAY_MS = 1000,
    parameter int POINT_HOLD_MS  = 500
) (
    input  logic               clk_1ms,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               pause,
    input  logic               p1_point,
    input  logic               p2_point,
    output logic [STATE_W-1:0] state,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               ball_enable,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic               game_end,
    output logic               winner
);

    localparam int TMR_MAX = (SERVE_DELAY_MS > POINT_HOLD_MS) ? SERVE_DELAY_MS : POINT_HOLD_MS;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0]   SERVE_LAST = TMR_W'(SERVE_DELAY_MS - 1);
    localparam logic [TMR_W-1:0]   POINT_LAST = TMR_W'(POINT_HOLD_MS - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SAT        = '1;

    state_t             state_q, state_d;
    logic               start_q, start_rise;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic               dir_q, dir_d, win_q, win_d;
    logic               tmr_run, tmr_clr, tmr_exp;
    logic [TMR_W-1:0]   tmr_last;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SAT) ? SAT : v + 1'b1;
    endfunction

    assign start_rise = start_btn && !start_q;

    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        dir_d   = dir_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = SERVE;
                    p1_d    = '0;
                    p2_d    = '0;
                end
            end
            SERVE: begin
                if (tmr_exp) state_d = RALLY;
            end
            RALLY: begin
                // Simultaneous misses are a let: replay without scoring.
                if (p1_point && p2_point) begin
                    state_d = POINT;
                end else if (p1_point) begin
                    state_d = POINT;
                    p1_d    = sat_inc(p1_q);
                    dir_d   = SERVE_TO_P2;
                end else if (p2_point) begin
                    state_d = POINT;
                    p2_d    = sat_inc(p2_q);
                    dir_d   = SERVE_TO_P1;
                end
            end
            POINT: begin
                if (tmr_exp) begin
                    if (p1_q >= WIN || p2_q >= WIN) begin
                        state_d = OVER;
                        win_d   = (p2_q >= WIN);
                    end else begin
                        state_d = SERVE;
                    end
                end
            end
            OVER: begin
                if (start_rise) begin
                    state_d = SERVE;
                    p1_d    = '0;
                    p2_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            p1_q    <= '0;
            p2_q    <= '0;
            dir_q   <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_btn;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            dir_q   <= dir_d;
            win_q   <= win_d;
        end
    end

    // One timer serves both timed phases; any phase change restarts it.
    assign tmr_last = (state_q == POINT) ? POINT_LAST : SERVE_LAST;
    assign tmr_run  = ((state_q == SERVE) || (state_q == POINT)) && !pause;
    assign tmr_clr  = (state_d != state_q);

    phase_timer #(
        .W(TMR_W)
    ) u_phase_timer (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .clear   (tmr_clr),
        .run     (tmr_run),
        .last    (tmr_last),
        .expired (tmr_exp)
    );

    assign state       = state_q;
    assign p1_score    = p1_q;
    assign p2_score    = p2_q;
    assign serve_dir   = dir_q;
    assign winner      = win_q;
    assign game_end    = (state_q == OVER);
    assign ball_reset  = (state_q == IDLE) || (state_q == SERVE) || (state_q == OVER);
    assign ball_enable = (state_q == RALLY) && !pause;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with a point-event scoreboard.
module tb_match_sequencer;
    import game_pkg::*;

    logic       clk_1ms   = 1'b0;
    logic       reset     = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause     = 1'b0;
    logic       p1_point  = 1'b0;
    logic       p2_point  = 1'b0;
    logic [2:0] state;
    logic [2:0] p1_score, p2_score;
    logic       ball_enable, ball_reset, serve_dir, game_end, winner;

    typedef struct packed {
        logic [2:0] p1;
        logic [2:0] p2;
        logic       dir;
    } exp_t;

    exp_t       sb_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [2:0] m_p1   = 3'd0;
    logic [2:0] m_p2   = 3'd0;
    logic       m_dir  = 1'b0;

    match_sequencer #(
        .WIN_SCORE      (7),
        .SCORE_W        (3),
        .SERVE_DELAY_MS (1000),
        .POINT_HOLD_MS  (500)
    ) dut (
        .clk_1ms     (clk_1ms),
        .reset       (reset),
        .start_btn   (start_btn),
        .pause       (pause),
        .p1_point    (p1_point),
        .p2_point    (p2_point),
        .state       (state),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .ball_enable (ball_enable),
        .ball_reset  (ball_reset),
        .serve_dir   (serve_dir),
        .game_end    (game_end),
        .winner      (winner)
    );

    always #5 clk_1ms = ~clk_1ms;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_1ms);
    endtask

    task automatic expect_state(input int n, input state_t s, input string tag);
        step(n);
        chk(tag, 32'(state), 32'(s));
    endtask

    // Model the scoring outcome, push it, drive the pulse, then pop and compare.
    task automatic point(input logic a, input logic b, input string tag);
        exp_t e, got;
        if (a && !b) begin
            m_p1  = (m_p1 == 3'd7) ? 3'd7 : m_p1 + 3'd1;
            m_dir = 1'b1;
        end else if (b && !a) begin
            m_p2  = (m_p2 == 3'd7) ? 3'd7 : m_p2 + 3'd1;
            m_dir = 1'b0;
        end
        sb_q.push_back('{p1: m_p1, p2: m_p2, dir: m_dir});
        p1_point = a;
        p2_point = b;
        step(1);
        p1_point = 1'b0;
        p2_point = 1'b0;
        chk({tag, "_state"}, 32'(state), 32'(POINT));
        e   = sb_q.pop_front();
        got = '{p1: p1_score, p2: p2_score, dir: serve_dir};
        chk({tag, "_sb"}, 32'(got), 32'(e));
    endtask

    initial begin
        step(2);
        chk("rst_state", 32'(state), 32'(IDLE));
        chk("rst_scores", 32'({p1_score, p2_score}), 32'd0);
        chk("rst_outs", 32'({ball_enable, ball_reset, game_end, serve_dir, winner}), 32'b01000);
        reset = 1'b1;
        step(3);
        chk("idle_hold", 32'(state), 32'(IDLE));

        // Start press held high for the whole serve: must not retrigger.
        start_btn = 1'b1;
        expect_state(1, SERVE, "start_serve");
        chk("serve_ball_reset", 32'(ball_reset), 32'd1);
        expect_state(999, SERVE, "serve_999");
        expect_state(1, RALLY, "serve_1000_rally");
        chk("rally_ball_en", 32'({ball_enable, ball_reset}), 32'b10);

        // Paused rally still scores.
        pause = 1'b1;
        step(1);
        chk("pause_ball_en", 32'(ball_enable), 32'd0);
        chk("pause_rally_hold", 32'(state), 32'(RALLY));
        point(1'b1, 1'b0, "p1_paused");
        pause = 1'b0;
        start_btn = 1'b0;
        expect_state(499, POINT, "hold_499");
        expect_state(1, SERVE, "hold_500_serve");

        // 200 paused ticks in SERVE delay the release by exactly 200.
        step(300);
        pause = 1'b1;
        step(200);
        pause = 1'b0;
        expect_state(699, SERVE, "pause_serve_hold");
        expect_state(1, RALLY, "pause_serve_rally");

        // Let: both points in one tick.
        point(1'b1, 1'b1, "let");
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        expect_state(499, SERVE, "let_restart_ignored");
        expect_state(1000, RALLY, "let_rally");

        // P2 wins the match.
        for (int i = 1; i <= 7; i++) begin
            point(1'b0, 1'b1, "p2_pt");
            if (i < 7) begin
                expect_state(500, SERVE, "p2_serve");
                expect_state(1000, RALLY, "p2_rally");
            end else begin
                expect_state(500, OVER, "over");
            end
        end
        chk("over_flags", 32'({game_end, winner, ball_reset, ball_enable}), 32'b1110);

        p1_point = 1'b1;
        step(1);
        p1_point = 1'b0;
        step(1);
        chk("over_frozen", 32'({p1_score, p2_score}), 32'({3'd1, 3'd7}));
        chk("over_stays", 32'(state), 32'(OVER));

        start_btn = 1'b1;
        m_p1 = 3'd0;
        m_p2 = 3'd0;
        expect_state(1, SERVE, "restart");
        start_btn = 1'b0;
        chk("restart_scores", 32'({p1_score, p2_score}), 32'd0);
        chk("restart_dir_end", 32'({serve_dir, game_end}), 32'b00);
        expect_state(1000, RALLY, "restart_rally");
        point(1'b1, 1'b0, "p1_after_restart");
        expect_state(1500, RALLY, "pre_reset_rally");

        // Asynchronous reset mid-rally, checked before the next clock edge.
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'(IDLE));
        chk("async_rst_scores", 32'({p1_score, p2_score}), 32'd0);
        chk("async_rst_ball", 32'({ball_reset, ball_enable}), 32'b10);
        step(1);
        reset = 1'b1;
        step(2);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
